// File: rtl/ssm_mux_word_assembler.sv
// ssm_mux_word_assembler
// Cuts an MSB-first bitstream, delivered in IN_W-bit chunks, into mux words
// of ssm_max_se_size bits and serves them one per request from a small FIFO.
//
// Bit accumulator layout: the earliest valid bit sits at acc[ACC_W-1] and the
// 'count' valid bits fill downward from there; everything below is zero. That
// makes a cut a left shift and an accept an OR at offset 'count'.
//
// Optional build macro: SSM_MUX_WORD_ASSEMBLER_STATS_EN adds the saturating
// underflow_cnt / stall_cnt outputs. Without it those ports do not exist.

module ssm_mux_word_assembler #(
    parameter int IN_W       = 64,
    parameter int ACC_W      = 320,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [7:0]      ssm_max_se_size,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mux_word_request,
    output logic            mux_word_valid,
    output logic [255:0]    mux_word,
    output logic [3:0]      fifo_level
`ifdef SSM_MUX_WORD_ASSEMBLER_STATS_EN
    ,
    output logic [15:0]     underflow_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int CW    = 9;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] IN_W_C     = CW'(IN_W);
    localparam logic [CW-1:0] ACC_W_C    = CW'(ACC_W);
    localparam logic [CW-1:0] READY_MAX  = CW'(ACC_W - IN_W);
    localparam logic [3:0]    LEVEL_FULL = 4'(FIFO_DEPTH);

    // Elaboration-time parameter sanity checks
    if (!(IN_W == 64 || IN_W == 128 || IN_W == 256)) begin : g_bad_in_w
        $error("ssm_mux_word_assembler: IN_W must be 64, 128 or 256");
    end
    if (ACC_W < 255 + IN_W || ACC_W > 511) begin : g_bad_acc_w
        $error("ssm_mux_word_assembler: ACC_W must be >= 255+IN_W and fit a 9-bit count");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ssm_mux_word_assembler: FIFO_DEPTH must be a power of 2 in 2..8");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [255:0]     fifo_mem [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic             clr;
    logic [CW-1:0]    size_ext;
    logic             fifo_full;
    logic             cut;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_cut;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    cut_shamt;
    logic [ACC_W-1:0] acc_shifted;
    logic [ACC_W-1:0] chunk_placed;
    logic [ACC_W-1:0] acc_next;
    logic [255:0]     word_cut;
    logic [3:0]       level_next;

    // Cut/accept/pop decisions and the accumulator update
    always_comb begin
        clr          = rst | flush;
        size_ext     = {1'b0, ssm_max_se_size};
        fifo_full    = (fifo_level == LEVEL_FULL);
        cut          = (count >= size_ext) && !fifo_full;
        accept       = in_valid && in_ready;
        push         = cut && !clr;
        pop          = mux_word_request && (fifo_level != 4'd0) && !clr;

        count_cut    = cut ? (count - size_ext) : count;
        count_next   = accept ? (count_cut + IN_W_C) : count_cut;

        // Earliest size bits, right-justified; upper bits fall off as zero
        cut_shamt    = ACC_W_C - size_ext;
        word_cut     = 256'(acc >> cut_shamt);

        acc_shifted  = cut ? (acc << ssm_max_se_size) : acc;
        chunk_placed = {in_data, {(ACC_W - IN_W){1'b0}}} >> count_cut;
        acc_next     = accept ? (acc_shifted | chunk_placed) : acc_shifted;

        level_next   = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + 4'd1;
            2'b01:   level_next = fifo_level - 4'd1;
            default: level_next = fifo_level;
        endcase
    end

    // Accumulator, count and registered back-pressure
    always_ff @(posedge clk) begin
        if (clr) begin
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            acc      <= acc_next;
            count    <= count_next;
            in_ready <= (count_next <= READY_MAX);
        end
    end

    // Word FIFO storage; contents are only ever read after being written
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= word_cut;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_next;
        end
    end

    // Output register: one-cycle valid per pop, word held otherwise
    always_ff @(posedge clk) begin
        if (clr) begin
            mux_word_valid <= 1'b0;
            mux_word       <= '0;
        end else begin
            mux_word_valid <= pop;
            if (pop) begin
                mux_word <= fifo_mem[rd_ptr];
            end
        end
    end

`ifdef SSM_MUX_WORD_ASSEMBLER_STATS_EN
    // Saturating counts of dropped requests and back-pressured cycles
    always_ff @(posedge clk) begin
        if (clr) begin
            underflow_cnt <= '0;
            stall_cnt     <= '0;
        end else begin
            if (mux_word_request && (fifo_level == 4'd0) && (underflow_cnt != 16'hFFFF)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
            if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ssm_mux_word_assembler.sv
// Testbench for ssm_mux_word_assembler (default parameters).
// Accepted chunk bits are pushed into a bit queue; every delivered mux word
// pops ssm_max_se_size bits from it and is compared against the DUT.

module tb_ssm_mux_word_assembler;

    localparam int IN_W       = 64;
    localparam int ACC_W      = 320;
    localparam int FIFO_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [7:0]      ssm_max_se_size;
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            mux_word_request;
    logic            mux_word_valid;
    logic [255:0]    mux_word;
    logic [3:0]      fifo_level;
`ifdef SSM_MUX_WORD_ASSEMBLER_STATS_EN
    logic [15:0]     underflow_cnt;
    logic [15:0]     stall_cnt;
`endif

    ssm_mux_word_assembler #(
        .IN_W      (IN_W),
        .ACC_W     (ACC_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ssm_max_se_size (ssm_max_se_size),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .mux_word_request(mux_word_request),
        .mux_word_valid  (mux_word_valid),
        .mux_word        (mux_word),
        .fifo_level      (fifo_level)
`ifdef SSM_MUX_WORD_ASSEMBLER_STATS_EN
        ,
        .underflow_cnt   (underflow_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int words_seen = 0;
    bit sb[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [IN_W-1:0] rand_chunk();
        logic [IN_W-1:0] r;
        r = '0;
        for (int i = 0; i < IN_W / 32; i++) r = (r << 32) | IN_W'($urandom());
        return r;
    endfunction

    // One clock: scoreboard work at the falling edge, return 1 after rising edge
    task automatic cyc();
        logic [255:0] w;
        @(negedge clk);
        if (mux_word_valid) begin
            words_seen++;
            if (sb.size() < int'(ssm_max_se_size)) begin
                chk("sb_underrun", 256'(sb.size()), 256'(ssm_max_se_size));
                sb.delete();
            end else begin
                w = '0;
                for (int i = 0; i < int'(ssm_max_se_size); i++) w = {w[254:0], sb.pop_front()};
                chk("sb_word", mux_word, w);
            end
        end
        if (flush || rst) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            for (int i = IN_W - 1; i >= 0; i--) sb.push_back(in_data[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [7:0] sz);
        flush = 1'b1;
        ssm_max_se_size = sz;
        in_valid = 1'b0;
        mux_word_request = 1'b0;
        cyc();
        flush = 1'b0;
    endtask

    // Present a chunk until accepted; in_valid is left high for back-to-back use
    task automatic send(input logic [IN_W-1:0] d, input string tag);
        bit taken;
        int k;
        in_valid = 1'b1;
        in_data  = d;
        taken = 1'b0;
        k = 0;
        while (!taken && k < 50) begin
            taken = in_ready;
            cyc();
            k++;
        end
        if (!taken) chk({tag, "_accept_timeout"}, 256'(taken), 256'(1));
    endtask

    task automatic wait_level(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (fifo_level != 4'(n) && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 256'(fifo_level), 256'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] a, b, c;
        logic [7:0] sizes [4];
        int ws;

        rst = 1'b1;
        flush = 1'b0;
        ssm_max_se_size = 8'd128;
        in_data = '0;
        in_valid = 1'b0;
        mux_word_request = 1'b0;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_valid", 256'(mux_word_valid), 256'(0));
        chk("rst_word", mux_word, 256'(0));
        chk("rst_level", 256'(fifo_level), 256'(0));
        rst = 1'b0;

        // Test 1: size 128, two chunks make one word
        do_flush(8'd128);
        chk("t1_ready_after_flush", 256'(in_ready), 256'(0));
        cyc();
        chk("t1_ready_next", 256'(in_ready), 256'(1));
        a = {(IN_W / 4){4'hA}};
        b = {(IN_W / 4){4'h5}};
        send(a, "t1a");
        send(b, "t1b");
        in_valid = 1'b0;
        wait_level(1, 10, "t1_level");
        mux_word_request = 1'b1;
        cyc();
        mux_word_request = 1'b0;
        chk("t1_valid", 256'(mux_word_valid), 256'(1));
        chk("t1_word", mux_word, {128'h0, a, b});
        cyc();
        chk("t1_valid_one_cycle", 256'(mux_word_valid), 256'(0));
        chk("t1_word_held", mux_word, {128'h0, a, b});

        // Test 4: request while empty is dropped, a later one is served
        chk("t4_level_empty", 256'(fifo_level), 256'(0));
        mux_word_request = 1'b1;
        cyc();
        mux_word_request = 1'b0;
        chk("t4_no_valid", 256'(mux_word_valid), 256'(0));
        send(rand_chunk(), "t4a");
        send(rand_chunk(), "t4b");
        in_valid = 1'b0;
        wait_level(1, 10, "t4_level");
        mux_word_request = 1'b1;
        cyc();
        mux_word_request = 1'b0;
        chk("t4_valid", 256'(mux_word_valid), 256'(1));
        cyc();

        // Test 2: size 255, word boundary inside the fourth chunk
        do_flush(8'd255);
        for (int i = 0; i < 4; i++) send(rand_chunk(), "t2");
        in_valid = 1'b0;
        wait_level(1, 10, "t2_level1");
        chk("t2_ready_count1", 256'(in_ready), 256'(1));
        for (int i = 0; i < 4; i++) send(rand_chunk(), "t2b");
        in_valid = 1'b0;
        wait_level(2, 10, "t2_level2");
        ws = words_seen;
        mux_word_request = 1'b1;
        cyc();
        cyc();
        mux_word_request = 1'b0;
        cyc();
        chk("t2_words", 256'(words_seen - ws), 256'(2));

        // Test 3: size 16, no requests, FIFO saturates then in_ready falls
        do_flush(8'd16);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = rand_chunk();
            cyc();
        end
        chk("t3_level_full", 256'(fifo_level), 256'(FIFO_DEPTH));
        chk("t3_ready_low", 256'(in_ready), 256'(0));
        in_valid = 1'b0;
        ws = words_seen;
        mux_word_request = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        mux_word_request = 1'b0;
        cyc();
        cyc();
        chk("t3_words", 256'(words_seen - ws), 256'(8));

        // Test 5: flush with a pending pop and FIFO at level 3
        do_flush(8'd16);
        send(rand_chunk(), "t5a");
        in_valid = 1'b0;
        wait_level(3, 10, "t5_level3");
        flush = 1'b1;
        mux_word_request = 1'b1;
        cyc();
        flush = 1'b0;
        mux_word_request = 1'b0;
        chk("t5_valid_cancel", 256'(mux_word_valid), 256'(0));
        chk("t5_level_clear", 256'(fifo_level), 256'(0));
        chk("t5_ready_clear", 256'(in_ready), 256'(0));
        cyc();
        chk("t5_ready_back", 256'(in_ready), 256'(1));
        c = rand_chunk();
        send(c, "t5b");
        in_valid = 1'b0;
        wait_level(1, 10, "t5_level_post");
        mux_word_request = 1'b1;
        cyc();
        mux_word_request = 1'b0;
        chk("t5_valid_post", 256'(mux_word_valid), 256'(1));
        chk("t5_word_post", mux_word, {240'h0, c[IN_W-1 -: 16]});
        cyc();

        // Test 6: random streams for several sizes
        sizes[0] = 8'd16;
        sizes[1] = 8'd97;
        sizes[2] = 8'd200;
        sizes[3] = 8'd255;
        for (int s = 0; s < 4; s++) begin
            do_flush(sizes[s]);
            ws = words_seen;
            for (int i = 0; i < 300; i++) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = rand_chunk();
                mux_word_request = ($urandom_range(0, 3) == 0);
                cyc();
            end
            in_valid = 1'b0;
            mux_word_request = 1'b1;
            for (int i = 0; i < 120; i++) cyc();
            mux_word_request = 1'b0;
            cyc();
            cyc();
            chk("t6_drain_level", 256'(fifo_level), 256'(0));
            chk("t6_words_seen", 256'(words_seen - ws > 0), 256'(1));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
